// File: rtl/mem_axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI memory bridge: FSM states, request
// sources and the CPU size codes with their AXI size mapping.
package mem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // AXI encodes transfer size as log2(bytes), which the CPU codes already are.
  function automatic logic [2:0] axi_size(input logic [1:0] cpu_size);
    return {1'b0, cpu_size};
  endfunction

endpackage

// File: rtl/mem_axi_bridge.sv
// Single-outstanding bridge from the CPU fetch/load-store ports to an AXI
// master; data requests win arbitration and the served requester is unstalled
// for exactly the one DONE cycle.
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_sel,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_stall,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  state_e                r_state;
  src_e                  r_src;
  logic [ADDR_W-1:0]     r_addr;
  logic [2:0]            r_size;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_strb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [DATA_W-1:0]     r_inst_rdata;
  logic [DATA_W-1:0]     r_data_rdata;

  logic                  w_aw_ok;
  logic                  w_w_ok;
  logic                  w_done_inst;
  logic                  w_done_data;

  // A handshake counts as complete if it happened earlier or is happening now.
  assign w_aw_ok = r_aw_done | awready;
  assign w_w_ok  = r_w_done | wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_src        <= SRC_INST;
      r_addr       <= {ADDR_W{1'b0}};
      r_size       <= 3'b000;
      r_wdata      <= {DATA_W{1'b0}};
      r_strb       <= {(DATA_W/8){1'b0}};
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_rdata <= {DATA_W{1'b0}};
      r_data_rdata <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (data_req) begin
            r_src   <= SRC_DATA;
            r_addr  <= data_addr;
            r_size  <= axi_size(data_size);
            r_wdata <= data_wdata;
            r_strb  <= data_sel;
            r_state <= data_wr ? ST_WR_REQ : ST_RD_ADDR;
          end else if (inst_req) begin
            r_src   <= SRC_INST;
            r_addr  <= inst_addr;
            r_size  <= axi_size(SIZE_WORD);
            r_wdata <= {DATA_W{1'b0}};
            r_strb  <= {(DATA_W/8){1'b0}};
            r_state <= ST_RD_ADDR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (arready) begin
            r_state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            if (r_src == SRC_DATA) begin
              r_data_rdata <= rdata;
            end else begin
              r_inst_rdata <= rdata;
            end
            r_state <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          r_aw_done <= w_aw_ok;
          r_w_done  <= w_w_ok;
          if (w_aw_ok && w_w_ok) begin
            r_state <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // AXI controls decode directly from registered state, so they drop the
  // instant reset forces IDLE.
  assign arvalid = (r_state == ST_RD_ADDR);
  assign rready  = (r_state == ST_RD_DATA);
  assign awvalid = (r_state == ST_WR_REQ) & ~r_aw_done;
  assign wvalid  = (r_state == ST_WR_REQ) & ~r_w_done;
  assign bready  = (r_state == ST_WR_RESP);

  assign araddr  = r_addr;
  assign arsize  = r_size;
  assign awaddr  = r_addr;
  assign awsize  = r_size;
  assign wdata   = r_wdata;
  assign wstrb   = r_strb;

  assign w_done_inst = (r_state == ST_DONE) && (r_src == SRC_INST);
  assign w_done_data = (r_state == ST_DONE) && (r_src == SRC_DATA);
  assign inst_stall  = inst_req & ~w_done_inst;
  assign data_stall  = data_req & ~w_done_data;

  assign inst_rdata  = r_inst_rdata;
  assign data_rdata  = r_data_rdata;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed plus randomized bench for mem_axi_bridge with a delay-programmable
// AXI slave and a transaction-level expectation model.
module tb_mem_axi_bridge;
  import mem_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int n_checks = 0;
  int n_errors = 0;

  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] rd_word = 32'h0;

  logic [31:0] q_ar_addr[$];
  logic [2:0]  q_ar_size[$];
  logic [31:0] q_aw_addr[$];
  logic [2:0]  q_aw_size[$];
  logic [31:0] q_w_data[$];
  logic [3:0]  q_w_strb[$];
  int n_r = 0;
  int n_b = 0;

  logic [31:0] exp_inst_rd = 32'h0;
  logic [31:0] exp_data_rd = 32'h0;

  mem_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_sel(data_sel),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_stall(data_stall),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // AXI slave: each ready/valid rises after its programmed number of waiting cycles
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (arvalid) begin arready = (ar_c >= ar_dly); ar_c++; end
      else begin arready = 1'b0; ar_c = 0; end
      if (rready) begin rvalid = (r_c >= r_dly); rdata = rvalid ? rd_word : 32'h0; r_c++; end
      else begin rvalid = 1'b0; rdata = 32'h0; r_c = 0; end
      if (awvalid) begin awready = (aw_c >= aw_dly); aw_c++; end
      else begin awready = 1'b0; aw_c = 0; end
      if (wvalid) begin wready = (w_c >= w_dly); w_c++; end
      else begin wready = 1'b0; w_c = 0; end
      if (bready) begin bvalid = (b_c >= b_dly); b_c++; end
      else begin bvalid = 1'b0; b_c = 0; end
    end
  end

  // Handshake monitor logging every completed AXI beat
  always @(posedge clk) begin
    if (arvalid && arready) begin q_ar_addr.push_back(araddr); q_ar_size.push_back(arsize); end
    if (awvalid && awready) begin q_aw_addr.push_back(awaddr); q_aw_size.push_back(awsize); end
    if (wvalid && wready) begin q_w_data.push_back(wdata); q_w_strb.push_back(wstrb); end
    if (rvalid && rready) n_r = n_r + 1;
    if (bvalid && bready) n_b = n_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from one source, served to completion; expected latency and
  // beats come from the slave delays and the request itself.
  task automatic run_txn(input bit is_data, input bit wr, input logic [1:0] sz,
                         input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rw, input string tag);
    int lat, exp_lat, b_ar, b_aw, b_w, b_r, b_b;
    logic first_ar, first_aw;
    logic [2:0] esz;
    b_ar = q_ar_addr.size(); b_aw = q_aw_addr.size(); b_w = q_w_data.size();
    b_r = n_r; b_b = n_b;
    rd_word = rw;
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_size = sz; data_sel = sel;
      data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    lat = 0;
    first_ar = 1'b0; first_aw = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin first_ar = arvalid; first_aw = awvalid; end
    end while ((is_data ? data_stall : inst_stall) && lat < 200);
    exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
    esz = is_data ? {1'b0, sz} : 3'b010;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " arvalid_next"}, {31'b0, first_ar}, {31'b0, ~wr});
    chk({tag, " awvalid_next"}, {31'b0, first_aw}, {31'b0, wr});
    if (!wr) begin
      chk({tag, " ar_count"}, q_ar_addr.size(), b_ar + 1);
      chk({tag, " r_count"}, n_r, b_r + 1);
      if (q_ar_addr.size() > b_ar) begin
        chk({tag, " araddr"}, q_ar_addr[b_ar], addr);
        chk({tag, " arsize"}, {29'b0, q_ar_size[b_ar]}, {29'b0, esz});
      end
      if (is_data) exp_data_rd = rw; else exp_inst_rd = rw;
      chk({tag, " aw_count"}, q_aw_addr.size(), b_aw);
    end else begin
      chk({tag, " aw_count"}, q_aw_addr.size(), b_aw + 1);
      chk({tag, " w_count"}, q_w_data.size(), b_w + 1);
      chk({tag, " b_count"}, n_b, b_b + 1);
      if (q_aw_addr.size() > b_aw) begin
        chk({tag, " awaddr"}, q_aw_addr[b_aw], addr);
        chk({tag, " awsize"}, {29'b0, q_aw_size[b_aw]}, {29'b0, esz});
      end
      if (q_w_data.size() > b_w) begin
        chk({tag, " wdata"}, q_w_data[b_w], wd);
        chk({tag, " wstrb"}, {28'b0, q_w_strb[b_w]}, {28'b0, sel});
      end
      chk({tag, " ar_count"}, q_ar_addr.size(), b_ar);
    end
    chk({tag, " inst_rdata"}, inst_rdata, exp_inst_rd);
    chk({tag, " data_rdata"}, data_rdata, exp_data_rd);
    data_req = 1'b0; inst_req = 1'b0;
    @(negedge clk);
    chk({tag, " idle_valids"}, {29'b0, arvalid, awvalid, wvalid}, 32'h0);
  endtask

  initial begin
    int lat, cnt, b_ar, b_r;
    bit inst_held, quiet;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_sel = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset valids", {27'b0, arvalid, rready, awvalid, wvalid, bready}, 32'h0);
    chk("reset stalls", {30'b0, inst_stall, data_stall}, 32'h0);
    chk("reset inst_rdata", inst_rdata, 32'h0);
    chk("reset data_rdata", data_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'hbfc00000, 32'h0, 32'h3c1d0001, "fetch_boot");
    aw_dly = 2; w_dly = 0;
    run_txn(1'b1, 1'b1, SIZE_WORD, 4'hF, 32'h80001000, 32'hdeadbeef, 32'h0, "store_word");
    aw_dly = 0;
    run_txn(1'b1, 1'b1, SIZE_BYTE, 4'b1000, 32'h80001003, 32'hab000000, 32'h0, "store_byte");
    run_txn(1'b1, 1'b0, SIZE_HALF, 4'b0011, 32'h80000022, 32'h0, 32'h0000beef, "load_half");
    run_txn(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'hbfc00004, 32'h0, 32'h24080005, "fetch_hold");

    // Simultaneous fetch and load: data goes first, fetch waits through both
    b_ar = q_ar_addr.size();
    rd_word = 32'h11223344;
    data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_WORD; data_sel = 4'hF;
    data_addr = 32'h80000010; inst_req = 1'b1; inst_addr = 32'hbfc00008;
    lat = 0; inst_held = 1'b1;
    do begin @(negedge clk); lat++; inst_held &= inst_stall; end while (data_stall && lat < 200);
    chk("both data latency", lat, 3);
    chk("both data_rdata", data_rdata, 32'h11223344);
    data_req = 1'b0;
    rd_word = 32'h55667788;
    do begin @(negedge clk); lat++; if (inst_stall) inst_held &= 1'b1; end while (inst_stall && lat < 200);
    chk("both inst held", {31'b0, inst_held}, 32'h1);
    chk("both total latency", lat, 7);
    chk("both inst_rdata", inst_rdata, 32'h55667788);
    chk("both ar_count", q_ar_addr.size(), b_ar + 2);
    if (q_ar_addr.size() >= b_ar + 2) begin
      chk("both ar first", q_ar_addr[b_ar], 32'h80000010);
      chk("both ar second", q_ar_addr[b_ar + 1], 32'hbfc00008);
    end
    exp_data_rd = 32'h11223344; exp_inst_rd = 32'h55667788;
    inst_req = 1'b0;
    @(negedge clk);

    r_dly = 10;
    run_txn(1'b1, 1'b0, SIZE_WORD, 4'hF, 32'h80000040, 32'h0, 32'hcafef00d, "slow_rvalid");
    r_dly = 0;

    for (int i = 0; i < 24; i++) begin
      bit d, w;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      d = ($urandom_range(0, 2) != 0);
      w = d & ($urandom_range(0, 1) == 1);
      run_txn(d, w, 2'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom, $urandom,
              $sformatf("rand%0d", i));
    end
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;

    // Flush: request withdrawn mid-transaction, bus transaction still finishes
    r_dly = 3;
    b_ar = q_ar_addr.size(); b_r = n_r;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000080; rd_word = 32'h0badc0de;
    repeat (2) @(negedge clk);
    data_req = 1'b0;
    #1;
    chk("flush stall drop", {31'b0, data_stall}, 32'h0);
    repeat (8) @(negedge clk);
    chk("flush ar_count", q_ar_addr.size(), b_ar + 1);
    chk("flush r_count", n_r, b_r + 1);
    chk("flush idle", {30'b0, arvalid, rready}, 32'h0);

    // Reset while waiting for read data
    r_dly = 50;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000100;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!rready && cnt < 20);
    chk("rst reached rd_data", {31'b0, rready}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst ar/r drop", {30'b0, arvalid, rready}, 32'h0);
    chk("rst stalls", {30'b0, inst_stall, data_stall}, {30'b0, inst_req, data_req});
    chk("rst rdata clear", inst_rdata | data_rdata, 32'h0);
    exp_inst_rd = 32'h0; exp_data_rd = 32'h0;
    @(negedge clk);
    rst = 1'b0; data_req = 1'b0; r_dly = 0;
    quiet = 1'b1;
    repeat (5) begin @(negedge clk); quiet &= ~(arvalid | awvalid | wvalid | rready | bready); end
    chk("post-rst quiet", {31'b0, quiet}, 32'h1);
    run_txn(1'b0, 1'b0, SIZE_WORD, 4'h0, 32'hbfc00100, 32'h0, 32'h8fbf0010, "post_rst_fetch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_axi_bridge.md
MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 inst_req  input  1  fetch request, level, held until inst_stall falls.
REQ-006 inst_addr  input  32  fetch address (pcF).
REQ-007 inst_rdata  output  32  fetched word, valid in cycle inst_stall falls.
REQ-008 inst_stall  output  1  stall request to hazard unit (stallreq_from_if).
REQ-009 data_req  input  1  M-stage load/store request, level, held until data_stall falls.
REQ-010 data_wr  input  1  1 store, 0 load.
REQ-011 data_size  input  2  00 byte, 01 half, 10 word (sizeM).
REQ-012 data_sel  input  4  byte lane enables (sel).
REQ-013 data_addr  input  32  byte address (aluoutM).
REQ-014 data_wdata  input  32  lane-aligned store data (writedata2M).
REQ-015 data_rdata  output  32  load word, valid in cycle data_stall falls.
REQ-016 data_stall  output  1  stall request (stallreq_from_mem).
REQ-017 araddr/arsize/arvalid  output  32/3/1  AXI read address; arready input 1.
REQ-018 rdata/rvalid  input  32/1  AXI read data; rready output 1.
REQ-019 awaddr/awsize/awvalid  output  32/3/1  AXI write address; awready input 1.
REQ-020 wdata/wstrb/wvalid  output  32/4/1  AXI write data; wready input 1.
REQ-021 bvalid  input  1  AXI write response; bready output 1.

Function
REQ-022 SHALL implement FSM IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; one transaction outstanding.
REQ-023 IDLE: data_req takes priority over inst_req; selected request latched into addr/size/wdata/strb/source registers on the capture edge.
REQ-024 IDLE->RD_ADDR on load or fetch; IDLE->WR_REQ on store; stay IDLE with no request.
REQ-025 RD_ADDR: arvalid=1 with latched addr; ->RD_DATA on arvalid&arready.
REQ-026 RD_DATA: rready=1; on rvalid, rdata latched into inst_rdata or data_rdata per source; ->DONE.
REQ-027 WR_REQ: awvalid and wvalid asserted together, each deasserted independently after its own handshake; ->WR_RESP once both done (same or different cycles).
REQ-028 WR_RESP: bready=1; ->DONE on bvalid.
REQ-029 DONE lasts exactly one cycle, stall of served source is 0, no new capture; ->IDLE.
REQ-030 x_stall = x_req & ~(state==DONE & source==x), combinational; unserved requester stays stalled.
REQ-031 arsize/awsize = {1'b0,data_size} for data; 3'b010 for fetch; wstrb = data_sel; addresses passed unmodified.
REQ-032 Minimum load/fetch latency with arready,rvalid tied 1: capture edge + 3 cycles to stall release (IDLE, RD_ADDR, RD_DATA, DONE).
REQ-033 Simultaneous inst_req and data_req: data served first, then fetch from IDLE; inst_stall held throughout.
REQ-034 Request dropped while stall high (flush) SHALL NOT abort the AXI transaction; it completes and result is discarded.
REQ-035 inst_rdata/data_rdata SHALL hold last value until next read of same source.
REQ-036 rresp/bresp not checked; error responses treated as success.

Reset
REQ-037 rst SHALL force state IDLE, all valid/ready outputs 0, rdata registers 0, latched request registers 0, immediately (asynchronous).
REQ-038 Reset mid-transaction SHALL abandon it; no AXI output asserted until rst falls and a new request arrives.

Structure
REQ-039 State encoding and size codes (BYTE/HALF/WORD) SHALL live in the shared defines header.
REQ-040 No sub-module; single FSM plus latch registers.

Verification
REQ-041 Fetch 0xbfc00000, slave zero-wait returns 0x3c1d0001 -> arvalid next cycle, inst_stall falls 3 cycles after capture with inst_rdata=0x3c1d0001.
REQ-042 Store word addr 0x80001000 data 0xdeadbeef sel 1111, awready 2 cycles after wready -> both handshakes, one bready, single DONE, wstrb=4'hF.
REQ-043 Store byte addr 0x80001003 sel 1000 -> awsize=000, wstrb=4'b1000.
REQ-044 inst_req and data_req (load 0x80000010) same cycle -> AR data first, then fetch AR; inst_stall stays 1 until second DONE.
REQ-045 rst asserted while in RD_DATA -> arvalid/rready 0 same cycle, state IDLE, stalls equal requests with no DONE.
REQ-046 rvalid delayed 10 cycles -> data_stall held 1 throughout, no duplicate arvalid.
